alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter DATA_W, default 32, meaning operand and multiply-result width; legal values 8..64.
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1, meaning width of the multiply iteration counter.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port valid_in  input  1  alu_op/funct/src_a/src_b carry a valid instruction this cycle.
REQ-006 Port alu_op  input  2  main-decoder ALU class (00 add, 01 sub, 10 R-type, 11 reserved).
REQ-007 Port funct  input  6  R-type function field.
REQ-008 Port src_a  input  DATA_W  multiplicand.
REQ-009 Port src_b  input  DATA_W  multiplier.
REQ-010 Port alu_control  output  3  ALU operation select.
REQ-011 Port illegal  output  1  valid_in with unsupported alu_op/funct combination.
REQ-012 Port stall  output  1  pipeline must hold current instruction.
REQ-013 Port mul_done  output  1  one-cycle pulse, mul_result valid.
REQ-014 Port mul_result  output  DATA_W  low DATA_W bits of src_a*src_b (unsigned).

Function
REQ-015 Decode (combinational, IDLE state): alu_op 00 -> 010; 01 -> 100; 10 with funct 100000 -> 010, 100010 -> 100, 101010 -> 110, 011100 -> 101; anything else -> 010.
REQ-016 illegal = valid_in AND state IDLE AND (alu_op==11 OR (alu_op==10 AND funct not in the four listed codes)); combinational, no state effect.
REQ-017 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 IDLE -> BUSY when valid_in=1, alu_op=10, funct=011100; on that edge capture src_a into multiplicand reg, src_b into multiplier reg, clear accumulator, load counter with DATA_W.
REQ-019 BUSY: each cycle, if multiplier LSB=1 add multiplicand to accumulator (mod 2^DATA_W); shift multiplicand left 1, multiplier right 1, decrement counter.
REQ-020 BUSY -> DONE on the edge where counter reaches 0 (exactly DATA_W BUSY cycles).
REQ-021 DONE -> IDLE unconditionally after one cycle; mul_done=1 only in DONE.
REQ-022 Latency: mul accepted at edge t -> mul_done high in cycle t+DATA_W+1 (DATA_W=32: 33 cycles after acceptance edge).
REQ-023 stall = 1 in the IDLE cycle where a mul is presented with valid_in=1, and in every BUSY cycle; stall = 0 in DONE and otherwise.
REQ-024 In BUSY and DONE, alu_control SHALL be 101 regardless of inputs; valid_in, alu_op, funct, src_a, src_b are ignored.
REQ-025 mul_result updates only on BUSY->DONE edge and holds until next such edge.
REQ-026 valid_in=0 in IDLE: no state change; alu_control still follows REQ-015 decode.
REQ-027 Operand 0 or multiplier with all bits 0: still runs full DATA_W cycles (fixed latency, no early exit).
REQ-028 Back-to-back mul: a mul presented in the DONE cycle is not accepted; it is accepted the following IDLE cycle (min issue interval DATA_W+2).

Reset
REQ-029 rst_n low at any time, including mid-BUSY, SHALL immediately force state IDLE, counter 0, accumulator/operand regs 0, mul_result 0, mul_done 0.
REQ-030 During and after reset with inputs idle: stall 0, illegal 0, alu_control per REQ-015 decode of current inputs.
REQ-031 An aborted multiply leaves no trace; first mul after rst_n rises runs full latency.

Verification
REQ-032 Decode sweep: all 4 alu_op x 64 funct with valid_in=1 -> alu_control and illegal exactly per REQ-015/016 (e.g. 10/100101 -> 010, illegal=1).
REQ-033 Mul DATA_W=32: src_a=0x0001_2345, src_b=0x0000_0100 -> stall high 33 cycles, mul_done at t+33, mul_result=0x0123_4500.
REQ-034 Overflow: src_a=0xFFFF_FFFF, src_b=0xFFFF_FFFF -> mul_result=0x0000_0001.
REQ-035 Input change during BUSY (src_a, funct toggled randomly) -> result unaffected, alu_control stays 101.
REQ-036 rst_n pulsed low at BUSY cycle 10 -> outputs zero asynchronously; new mul 3x5 afterwards -> 15 after full latency.
REQ-037 DATA_W=8 instance: 0x0F*0x11 -> mul_result=0xFF, mul_done 9 cycles after acceptance edge.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with an iterative shift-add unsigned multiplier.
// Multiplies take DATA_W BUSY cycles and a single DONE cycle that carries the result pulse.
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [2:0]        alu_control,
  output logic              illegal,
  output logic              stall,
  output logic              mul_done,
  output logic [DATA_W-1:0] mul_result
);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b100;
  localparam logic [2:0] CTRL_SLT = 3'b110;
  localparam logic [2:0] CTRL_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [2:0] dec_ctrl;
  logic       funct_known;
  logic       is_mul;

  always_comb begin
    dec_ctrl    = CTRL_ADD;
    funct_known = 1'b0;
    unique case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        funct_known = 1'b1;
        case (funct)
          FN_ADD:  dec_ctrl = CTRL_ADD;
          FN_SUB:  dec_ctrl = CTRL_SUB;
          FN_SLT:  dec_ctrl = CTRL_SLT;
          FN_MUL:  dec_ctrl = CTRL_MUL;
          default: begin
            dec_ctrl    = CTRL_ADD;
            funct_known = 1'b0;
          end
        endcase
      end
      default: dec_ctrl = CTRL_ADD;
    endcase
  end

  assign is_mul = (alu_op == 2'b10) && (funct == FN_MUL);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    alu_control = dec_ctrl;
    illegal     = 1'b0;
    stall       = 1'b0;
    mul_done    = 1'b0;

    case (state_q)
      IDLE: begin
        illegal = valid_in && ((alu_op == 2'b11) || ((alu_op == 2'b10) && !funct_known));
        if (valid_in && is_mul) begin
          stall    = 1'b1;
          state_d  = BUSY;
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = CNT_W'(DATA_W);
        end
      end
      BUSY: begin
        stall       = 1'b1;
        alu_control = CTRL_MUL;
        acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d     = mcand_q << 1;
        mplier_d    = mplier_q >> 1;
        cnt_d       = cnt_q - CNT_W'(1);
        // Last iteration: publish the sum including this cycle's partial product.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE: begin
        alu_control = CTRL_MUL;
        mul_done    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign mul_result = result_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode sweep, multiplies, reset abort, back-to-back issue,
// plus a DATA_W=8 instance. Inputs change off the rising edge; outputs sampled on the falling edge.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [2:0]  alu_control;
  logic        illegal, stall, mul_done;
  logic [31:0] mul_result;

  logic        v8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [5:0]  fn8 = 6'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [2:0]  ctrl8;
  logic        ill8, st8, done8;
  logic [7:0]  res8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op), .funct(funct),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .illegal(illegal),
    .stall(stall), .mul_done(mul_done), .mul_result(mul_result)
  );

  alu_ctrl_seq #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(v8), .alu_op(op8), .funct(fn8),
    .src_a(a8), .src_b(b8), .alu_control(ctrl8), .illegal(ill8),
    .stall(st8), .mul_done(done8), .mul_result(res8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    valid_in = 1'b0;
    alu_op   = 2'b00;
    funct    = 6'd0;
  endtask

  // Waits (bounded) for mul_done, counting BUSY cycles seen before it.
  task automatic wait_done(input bit scramble, output int busy, output bit bad, output bit seen);
    busy = 0;
    bad  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      busy++;
      if (stall !== 1'b1 || alu_control !== 3'b101) bad = 1'b1;
      if (scramble) begin
        src_a    = $urandom;
        funct    = 6'($urandom);
        alu_op   = 2'($urandom);
        valid_in = 1'($urandom);
      end
    end
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic do_mul32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                          input bit scramble, input string name);
    int busy;
    bit bad, seen;
    valid_in = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'b011100;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || illegal !== 1'b0 || mul_done !== 1'b0 || alu_control !== 3'b101) begin
      errors++;
      $display("FAIL %s_present: stall=%b illegal=%b mul_done=%b ctrl=%b, required 1 0 0 101",
               name, stall, illegal, mul_done, alu_control);
    end
    @(posedge clk); #1;
    if (!scramble) set_idle();
    wait_done(scramble, busy, bad, seen);
    checks++;
    if (!seen || busy != 32) begin
      errors++;
      $display("FAIL %s_latency: busy_cycles=%0d done_seen=%0b, required 32 1", name, busy, seen);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_busy_outputs: stall/alu_control deviated during BUSY, required 1/101", name);
    end
    checks++;
    if (mul_result !== expv) begin
      errors++;
      $display("FAIL %s_result: got 0x%08h, required 0x%08h", name, mul_result, expv);
    end
    checks++;
    if (stall !== 1'b0 || alu_control !== 3'b101) begin
      errors++;
      $display("FAIL %s_done_outputs: stall=%b ctrl=%b, required 0 101", name, stall, alu_control);
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (mul_done !== 1'b0 || mul_result !== expv || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: mul_done=%b result=0x%08h stall=%b, required 0 0x%08h 0",
               name, mul_done, mul_result, stall, expv);
    end
    $display("mul %s: 0x%08h * 0x%08h -> 0x%08h (%0d busy cycles)", name, a, b, mul_result, busy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || illegal !== 1'b0 || mul_done !== 1'b0 ||
        mul_result !== 32'd0 || alu_control !== 3'b010) begin
      errors++;
      $display("FAIL reset_state: stall=%b illegal=%b done=%b result=0x%08h ctrl=%b, required 0 0 0 0 010",
               stall, illegal, mul_done, mul_result, alu_control);
    end
    $display("reset: ctrl=%b stall=%b illegal=%b", alu_control, stall, illegal);
  endtask

  // Run while reset holds the FSM in IDLE so no mul can be accepted mid-sweep.
  task automatic test_decode();
    logic [2:0] ectrl;
    logic       eill;
    int         bad_vecs;
    bad_vecs = 0;
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        valid_in = 1'b1;
        alu_op   = 2'(op);
        funct    = 6'(f);
        #1;
        ectrl = 3'b010;
        eill  = 1'b0;
        case (op)
          0: ectrl = 3'b010;
          1: ectrl = 3'b100;
          2: begin
            if (f == 6'b100000)      ectrl = 3'b010;
            else if (f == 6'b100010) ectrl = 3'b100;
            else if (f == 6'b101010) ectrl = 3'b110;
            else if (f == 6'b011100) ectrl = 3'b101;
            else begin ectrl = 3'b010; eill = 1'b1; end
          end
          default: begin ectrl = 3'b010; eill = 1'b1; end
        endcase
        checks++;
        if (alu_control !== ectrl || illegal !== eill) begin
          errors++;
          bad_vecs++;
          $display("FAIL decode op=%0d funct=%06b: ctrl=%b illegal=%b, required %b %b",
                   op, f[5:0], alu_control, illegal, ectrl, eill);
        end
      end
    end
    $display("decode sweep: 256 vectors, %0d wrong", bad_vecs);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_no_valid();
    valid_in = 1'b0;
    alu_op   = 2'b10;
    funct    = 6'b011100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mul_done !== 1'b0 || alu_control !== 3'b101 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL idle_novalid_%0d: stall=%b done=%b ctrl=%b illegal=%b, required 0 0 101 0",
                 i, stall, mul_done, alu_control, illegal);
      end
    end
    funct = 6'b101010;
    @(negedge clk);
    checks++;
    if (alu_control !== 3'b110 || stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_slt: ctrl=%b stall=%b, required 110 0", alu_control, stall);
    end
    alu_op = 2'b11;
    @(negedge clk);
    checks++;
    if (alu_control !== 3'b010 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL idle_reserved_novalid: ctrl=%b illegal=%b, required 010 0", alu_control, illegal);
    end
    $display("idle without valid: ctrl=%b illegal=%b", alu_control, illegal);
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    valid_in = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'b011100;
    src_a    = 32'h0000_1111;
    src_b    = 32'h0000_2222;
    @(posedge clk); #1;
    set_idle();
    alu_op = 2'b01;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mul_done !== 1'b0 || mul_result !== 32'd0 ||
        alu_control !== 3'b100 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: stall=%b done=%b result=0x%08h ctrl=%b illegal=%b, required 0 0 0 100 0",
               stall, mul_done, mul_result, alu_control, illegal);
    end
    $display("reset at busy cycle 10: result=0x%08h stall=%b ctrl=%b", mul_result, stall, alu_control);
    #1 rst_n = 1'b1;
    alu_op = 2'b00;
    @(posedge clk); #1;
    do_mul32(32'd3, 32'd5, 32'd15, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int busy;
    bit bad, seen;
    valid_in = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'b011100;
    src_a    = 32'd7;
    src_b    = 32'd6;
    @(posedge clk); #1;
    wait_done(1'b0, busy, bad, seen);
    checks++;
    if (!seen || busy != 32 || mul_result !== 32'd42 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: seen=%0b busy=%0d result=0x%08h stall=%b, required 1 32 0x0000002a 0",
               seen, busy, mul_result, stall);
    end
    src_a = 32'd9;
    src_b = 32'd9;
    @(negedge clk);
    checks++;
    if (mul_done !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_present: done=%b stall=%b, required 0 1", mul_done, stall);
    end
    @(posedge clk); #1;
    set_idle();
    wait_done(1'b0, busy, bad, seen);
    checks++;
    if (!seen || busy != 32 || mul_result !== 32'd81) begin
      errors++;
      $display("FAIL b2b_second: seen=%0b busy=%0d result=0x%08h, required 1 32 0x00000051",
               seen, busy, mul_result);
    end
    $display("back-to-back: second result 0x%08h after %0d busy cycles", mul_result, busy);
    @(posedge clk); #1;
  endtask

  task automatic test_mul8();
    int busy8;
    bit seen8;
    v8  = 1'b1;
    op8 = 2'b10;
    fn8 = 6'b011100;
    a8  = 8'h0F;
    b8  = 8'h11;
    @(negedge clk);
    checks++;
    if (st8 !== 1'b1) begin
      errors++;
      $display("FAIL mul8_present: stall=%b, required 1", st8);
    end
    @(posedge clk); #1;
    v8  = 1'b0;
    op8 = 2'b00;
    busy8 = 0;
    seen8 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        seen8 = 1'b1;
        break;
      end
      busy8++;
    end
    checks++;
    if (!seen8 || busy8 != 8) begin
      errors++;
      $display("FAIL mul8_latency: busy_cycles=%0d seen=%0b, required 8 1", busy8, seen8);
    end
    checks++;
    if (res8 !== 8'hFF) begin
      errors++;
      $display("FAIL mul8_result: got 0x%02h, required 0xff", res8);
    end
    $display("mul8: 0x0f * 0x11 -> 0x%02h (%0d busy cycles)", res8, busy8);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_idle_no_valid();
    do_mul32(32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0, "basic");
    do_mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "overflow");
    do_mul32(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, "zero_mplier");
    do_mul32(32'h0000_ABCD, 32'h0000_0011, 32'h000B_689D, 1'b1, "scramble");
    test_mid_reset();
    test_back_to_back();
    test_mul8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
